// File: rtl/fifo_uart_drain_pkg.sv
// Shared definitions for the FIFO-to-UART drain: FSM encoding, word width and
// the default baud divisor for a 12 MHz clock at 115200 baud.
package fifo_uart_drain_pkg;

    localparam int CLK_HZ    = 12_000_000;
    localparam int BAUD_RATE = 115_200;

    // Integer truncation gives 104; the resulting ~0.2% rate error is well inside 8N1 tolerance.
    localparam int DEFAULT_BAUD_DIV = CLK_HZ / BAUD_RATE;

    localparam int FIFO_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_uart_drain_if.sv
// FIFO head/flag/pop handshake between fifo_stack (master) and its drain (slave).
interface fifo_uart_drain_if;
    import fifo_uart_drain_pkg::*;

    logic [FIFO_W-1:0] I_DATA;
    logic              empty;
    logic              fifo_busy;
    logic              pop;

    modport master (
        output I_DATA,
        output empty,
        output fifo_busy,
        input  pop
    );

    modport slave (
        input  I_DATA,
        input  empty,
        input  fifo_busy,
        output pop
    );

endinterface

// File: rtl/fifo_uart_drain_baud_tick.sv
// Bit-period timer: restarts from zero on load and flags the last cycle of
// every BAUD_DIV-cycle period. Usable unchanged by a UART receiver.
module fifo_uart_drain_baud_tick
    import fifo_uart_drain_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains fifo_stack one byte at a time and sends each byte as a UART 8N1 frame
// on TX. One shift register, no further buffering.
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int DATA_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    fifo_uart_drain_if.slave   fifo,
    output logic               TX,
    output logic               tx_busy
);

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [2:0]        bit_cnt_reg;
    logic              tx_reg;
    logic              pop_reg;
    logic              busy_reg;
    logic              launch;
    logic              tick;

    assign launch = (state_reg == IDLE) && enable && !fifo.empty && !fifo.fifo_busy;

    // Loading on the launch edge aligns the first tick with the end of the start bit.
    fifo_uart_drain_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .load  (launch),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            pop_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            pop_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        shift_reg <= fifo.I_DATA;
                        pop_reg   <= 1'b1;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_reg      <= shift_reg[0];
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= shift_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            tx_reg <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    // Returning to IDLE here guarantees one idle cycle before the next launch.
                    if (tick) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign fifo.pop = pop_reg;
    assign TX       = tx_reg;
    assign tx_busy  = busy_reg;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: a BAUD_DIV=4 instance for frame-level scenarios and a
// default-divisor instance for the full-rate timing check.
module tb_fifo_uart_drain;

    localparam int D  = 4;
    localparam int FL = 10 * D;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en_s  = 1'b0;
    logic en_d  = 1'b0;
    logic tx_s, busy_s, tx_d, busy_d;

    int compared   = 0;
    int mismatched = 0;
    int cycle_cnt  = 0;

    fifo_uart_drain_if sm_if ();
    fifo_uart_drain_if df_if ();

    fifo_uart_drain #(.BAUD_DIV(D)) dut_s (
        .clk     (clk),
        .reset   (reset),
        .enable  (en_s),
        .fifo    (sm_if.slave),
        .TX      (tx_s),
        .tx_busy (busy_s)
    );

    fifo_uart_drain dut_d (
        .clk     (clk),
        .reset   (reset),
        .enable  (en_d),
        .fifo    (df_if.slave),
        .TX      (tx_d),
        .tx_busy (busy_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Ideal 8N1 line level for each cycle of a frame: start, 8 data bits LSB first, stop.
    function automatic logic [FL-1:0] model_wave(input logic [7:0] b);
        logic [9:0] bits;
        logic [FL-1:0] w;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < FL; k++) w[k] = bits[k / D];
        return w;
    endfunction

    // Waits for pop, then records n cycles of TX; optionally changes inputs at cycle chg_k.
    task automatic observe_frame(input int budget, input int n, input int chg_k,
                                 input logic [7:0] chg_data, input logic chg_en,
                                 output bit timed_out, output int start_cyc,
                                 output logic [FL-1:0] wave, output int pops,
                                 output int busy_cnt);
        int waited;
        waited    = 0;
        timed_out = 1'b0;
        wave      = '1;
        pops      = 0;
        busy_cnt  = 0;
        start_cyc = -1;
        while (sm_if.pop !== 1'b1) begin
            if (waited >= budget) begin
                timed_out = 1'b1;
                return;
            end
            @(negedge clk);
            waited++;
        end
        start_cyc = cycle_cnt;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            wave[k]  = tx_s;
            pops     += (sm_if.pop === 1'b1) ? 1 : 0;
            busy_cnt += (busy_s === 1'b1) ? 1 : 0;
            if (k == chg_k) begin
                sm_if.I_DATA = chg_data;
                en_s         = chg_en;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (tx_s !== 1'b1 || busy_s !== 1'b0 || sm_if.pop !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_small: TX=%b tx_busy=%b pop=%b, required 1/0/0", tx_s, busy_s, sm_if.pop);
        end
        compared++;
        if (tx_d !== 1'b1 || busy_d !== 1'b0 || df_if.pop !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_default: TX=%b tx_busy=%b pop=%b, required 1/0/0", tx_d, busy_d, df_if.pop);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        bit to; int sc, pops, bc; logic [FL-1:0] w;
        sm_if.I_DATA = 8'h41; sm_if.empty = 1'b0; sm_if.fifo_busy = 1'b0; en_s = 1'b1;
        observe_frame(5, FL, 0, 8'h41, 1'b0, to, sc, w, pops, bc);
        compared++;
        if (to !== 1'b0) begin mismatched++; $display("FAIL basic_pop_seen: timed out, required pop within 5 cycles"); end
        compared++;
        if (w !== model_wave(8'h41)) begin
            mismatched++; $display("FAIL basic_wave: got %h required %h", w, model_wave(8'h41));
        end
        compared++;
        if (pops !== 1 || bc !== FL) begin
            mismatched++; $display("FAIL basic_pop_busy: pops=%0d busy=%0d required 1/%0d", pops, bc, FL);
        end
        @(negedge clk);
        compared++;
        if (tx_s !== 1'b1 || busy_s !== 1'b0 || sm_if.pop !== 1'b0) begin
            mismatched++; $display("FAIL basic_after: TX=%b tx_busy=%b pop=%b required 1/0/0", tx_s, busy_s, sm_if.pop);
        end
        $display("test_basic: byte 41 start cycle %0d", sc);
    endtask

    task automatic test_back_to_back();
        bit to1, to2; int sc1, sc2, p1, p2, b1, b2; logic [FL-1:0] w1, w2;
        sm_if.I_DATA = 8'h5B; sm_if.empty = 1'b0; en_s = 1'b1;
        observe_frame(5, FL, 0, 8'h63, 1'b1, to1, sc1, w1, p1, b1);
        observe_frame(5, FL, 0, 8'h63, 1'b0, to2, sc2, w2, p2, b2);
        compared++;
        if (to1 !== 1'b0 || to2 !== 1'b0) begin mismatched++; $display("FAIL b2b_pop_seen: timeouts %b/%b required 0/0", to1, to2); end
        compared++;
        if (w1 !== model_wave(8'h5B)) begin mismatched++; $display("FAIL b2b_wave1: got %h required %h", w1, model_wave(8'h5B)); end
        compared++;
        if (w2 !== model_wave(8'h63)) begin mismatched++; $display("FAIL b2b_wave2: got %h required %h", w2, model_wave(8'h63)); end
        compared++;
        if (sc2 - sc1 !== FL + 1) begin mismatched++; $display("FAIL b2b_period: got %0d required %0d", sc2 - sc1, FL + 1); end
        compared++;
        if (p1 !== 1 || p2 !== 1) begin mismatched++; $display("FAIL b2b_pops: got %0d/%0d required 1/1", p1, p2); end
        @(negedge clk);
        $display("test_back_to_back: starts %0d and %0d", sc1, sc2);
    endtask

    task automatic test_flow_gating();
        bit to; int sc, pops, bc, rel; logic [FL-1:0] w; logic [7:0] b;
        int g_pop, g_txhi, g_busy;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            sm_if.I_DATA    = b;
            sm_if.empty     = (i == 0);
            sm_if.fifo_busy = (i == 1);
            en_s            = (i != 2);
            g_pop = 0; g_txhi = 0; g_busy = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                g_pop  += (sm_if.pop === 1'b1) ? 1 : 0;
                g_txhi += (tx_s === 1'b1) ? 1 : 0;
                g_busy += (busy_s === 1'b1) ? 1 : 0;
            end
            compared++;
            if (g_pop !== 0 || g_txhi !== 50 || g_busy !== 0) begin
                mismatched++;
                $display("FAIL gate_%0d_hold: pops=%0d tx_high=%0d busy=%0d required 0/50/0", i, g_pop, g_txhi, g_busy);
            end
            sm_if.empty = 1'b0; sm_if.fifo_busy = 1'b0; en_s = 1'b1;
            rel = cycle_cnt;
            observe_frame(5, FL, 0, 8'h00, 1'b0, to, sc, w, pops, bc);
            compared++;
            if (to !== 1'b0 || sc !== rel + 1) begin
                mismatched++; $display("FAIL gate_%0d_release: pop cycle %0d required %0d", i, sc, rel + 1);
            end
            compared++;
            if (w !== model_wave(b)) begin mismatched++; $display("FAIL gate_%0d_wave: got %h required %h", i, w, model_wave(b)); end
            @(negedge clk);
            $display("test_flow_gating: case %0d byte %h", i, b);
        end
    endtask

    task automatic test_mid_frame();
        bit to; int sc, pops, bc, extra; logic [FL-1:0] w;
        sm_if.I_DATA = 8'h41; sm_if.empty = 1'b0; en_s = 1'b1;
        observe_frame(5, FL, 14, 8'hFF, 1'b0, to, sc, w, pops, bc);
        compared++;
        if (to !== 1'b0 || w !== model_wave(8'h41)) begin
            mismatched++; $display("FAIL midframe_wave: got %h required %h", w, model_wave(8'h41));
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            extra += (sm_if.pop === 1'b1) ? 1 : 0;
        end
        compared++;
        if (pops + extra !== 1) begin mismatched++; $display("FAIL midframe_pops: got %0d required 1", pops + extra); end
        $display("test_mid_frame: byte 41 kept");
    endtask

    task automatic test_reset_mid_frame();
        bit to; int sc, pops, bc, rel; logic [FL-1:0] w, m; logic [7:0] b1, b2;
        b1 = 8'($urandom); b2 = 8'($urandom);
        sm_if.I_DATA = b1; sm_if.empty = 1'b0; en_s = 1'b1;
        observe_frame(5, 18, -1, 8'h00, 1'b1, to, sc, w, pops, bc);
        m = model_wave(b1);
        compared++;
        if (to !== 1'b0 || w[17:0] !== m[17:0]) begin
            mismatched++; $display("FAIL rst_partial: got %h required %h", w[17:0], m[17:0]);
        end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (tx_s !== 1'b1 || busy_s !== 1'b0 || sm_if.pop !== 1'b0) begin
            mismatched++; $display("FAIL rst_mid: TX=%b tx_busy=%b pop=%b required 1/0/0", tx_s, busy_s, sm_if.pop);
        end
        @(negedge clk);
        compared++;
        if (sm_if.pop !== 1'b0 || busy_s !== 1'b0) begin
            mismatched++; $display("FAIL rst_vs_launch: pop=%b tx_busy=%b required 0/0", sm_if.pop, busy_s);
        end
        reset = 1'b0; sm_if.I_DATA = b2;
        rel = cycle_cnt;
        observe_frame(5, FL, 0, 8'h00, 1'b0, to, sc, w, pops, bc);
        compared++;
        if (to !== 1'b0 || sc !== rel + 1 || w !== model_wave(b2)) begin
            mismatched++; $display("FAIL rst_restart: start %0d required %0d, got %h required %h", sc, rel + 1, w, model_wave(b2));
        end
        @(negedge clk);
        $display("test_reset_mid_frame: bytes %h then %h", b1, b2);
    endtask

    task automatic test_random();
        bit to; int sc, pops, bc, gap; logic [FL-1:0] w; logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 5);
            sm_if.empty = ($urandom_range(0, 1) == 1);
            en_s = 1'b0;
            repeat (gap) @(negedge clk);
            sm_if.I_DATA = b; sm_if.empty = 1'b0; sm_if.fifo_busy = 1'b0; en_s = 1'b1;
            observe_frame(5, FL, $urandom_range(1, FL - 2), 8'($urandom), 1'b0, to, sc, w, pops, bc);
            compared++;
            if (to !== 1'b0 || w !== model_wave(b) || pops !== 1 || bc !== FL) begin
                mismatched++;
                $display("FAIL random_%0d: got %h pops=%0d busy=%0d required %h/1/%0d", i, w, pops, bc, model_wave(b), FL);
            end
            @(negedge clk);
            $display("test_random: frame %0d byte %h", i, b);
        end
    endtask

    task automatic test_default();
        int waited, low_cnt, high_cnt;
        df_if.I_DATA = 8'h00; df_if.empty = 1'b0; df_if.fifo_busy = 1'b0; en_d = 1'b1;
        waited = 0;
        while (df_if.pop !== 1'b1 && waited < 5) begin @(negedge clk); waited++; end
        en_d = 1'b0;
        low_cnt = 0;
        while (tx_d === 1'b0 && low_cnt < 2000) begin low_cnt++; @(negedge clk); end
        high_cnt = 0;
        while (tx_d === 1'b1 && busy_d === 1'b1 && high_cnt < 2000) begin high_cnt++; @(negedge clk); end
        compared++;
        if (low_cnt !== 936) begin mismatched++; $display("FAIL default_low: got %0d required 936", low_cnt); end
        compared++;
        if (high_cnt !== 104 || tx_d !== 1'b1 || busy_d !== 1'b0) begin
            mismatched++; $display("FAIL default_stop: high=%0d TX=%b tx_busy=%b required 104/1/0", high_cnt, tx_d, busy_d);
        end
        $display("test_default: low %0d high %0d", low_cnt, high_cnt);
    endtask

    initial begin
        sm_if.I_DATA = 8'h00; sm_if.empty = 1'b1; sm_if.fifo_busy = 1'b0;
        df_if.I_DATA = 8'h00; df_if.empty = 1'b1; df_if.fifo_busy = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_flow_gating();
        test_mid_frame();
        test_reset_mid_frame();
        test_random();
        test_default();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
